// File: rtl/universal_shift_register_pkg.sv
// universal_shift_register_pkg: mode encodings and decode helpers shared by the shift register
package universal_shift_register_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  function automatic logic is_shift(input logic [1:0] mode);
    return mode == MODE_SHL || mode == MODE_SHR;
  endfunction
endpackage

// File: rtl/universal_shift_register_if.sv
// universal_shift_register_if: control, data and word-handshake signals of the shift register
interface universal_shift_register_if #(parameter int WIDTH = 8);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic             Enable_In;
  logic [1:0]       Mode_In;
  logic             Serial_Data_In;
  logic [WIDTH-1:0] Parallel_Data_In;
  logic             Clear_Overrun_In;
  logic             Word_Ready_In;
  logic             Serial_Data_Out;
  logic [WIDTH-1:0] Shift_Register_Out;
  logic [WIDTH-1:0] Word_Data_Out;
  logic             Word_Valid_Out;
  logic             Overrun_Out;
  logic [CNT_W-1:0] Bit_Count_Out;
  modport master (
    output Enable_In, Mode_In, Serial_Data_In, Parallel_Data_In, Clear_Overrun_In, Word_Ready_In,
    input  Serial_Data_Out, Shift_Register_Out, Word_Data_Out, Word_Valid_Out, Overrun_Out, Bit_Count_Out
  );
  modport slave (
    input  Enable_In, Mode_In, Serial_Data_In, Parallel_Data_In, Clear_Overrun_In, Word_Ready_In,
    output Serial_Data_Out, Shift_Register_Out, Word_Data_Out, Word_Valid_Out, Overrun_Out, Bit_Count_Out
  );
endinterface

// File: rtl/universal_shift_register_word_ctrl.sv
// universal_shift_register_word_ctrl: bit counter, word capture, valid handshake and sticky overrun
module universal_shift_register_word_ctrl
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             ovr_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d, ovr_q, ovr_d, done;
  // a word completing while the previous one is still unaccepted overwrites it and flags the loss
  always_comb begin
    done    = shift_i && cnt_q == CNT_W'(WIDTH - 1);
    cnt_d   = (load_i || done) ? '0 : shift_i ? cnt_q + CNT_W'(1) : cnt_q;
    word_d  = done ? data_i : word_q;
    valid_d = done || (valid_q && !ready_i);
    ovr_d   = (done && valid_q && !ready_i) || (ovr_q && !clr_i);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end
  assign cnt_o   = cnt_q;
  assign word_o  = word_q;
  assign valid_o = valid_q;
  assign ovr_o   = ovr_q;
endmodule

// File: rtl/universal_shift_register.sv
// universal_shift_register: hold/shift-left/shift-right/load register with serial word assembly
module universal_shift_register
  import universal_shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                        Clk_In,
  input logic                        Reset_N_In,
  universal_shift_register_if.slave  bus
);
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             shift, load;
  always_comb begin
    shift = bus.Enable_In && is_shift(bus.Mode_In);
    load  = bus.Enable_In && bus.Mode_In == MODE_LOAD;
    sr_d  = !bus.Enable_In              ? sr_q :
            bus.Mode_In == MODE_SHL     ? {sr_q[WIDTH-2:0], bus.Serial_Data_In} :
            bus.Mode_In == MODE_SHR     ? {bus.Serial_Data_In, sr_q[WIDTH-1:1]} :
            bus.Mode_In == MODE_LOAD    ? bus.Parallel_Data_In : sr_q;
  end
  always_ff @(posedge Clk_In) begin
    if (!Reset_N_In) sr_q <= '0;
    else             sr_q <= sr_d;
  end
  assign bus.Shift_Register_Out = sr_q;
  assign bus.Serial_Data_Out    = bus.Mode_In == MODE_SHR ? sr_q[0] : sr_q[WIDTH-1];
  universal_shift_register_word_ctrl #(.WIDTH(WIDTH)) u_word_ctrl (
    .clk     (Clk_In),
    .rst_n   (Reset_N_In),
    .shift_i (shift),
    .load_i  (load),
    .data_i  (sr_d),
    .ready_i (bus.Word_Ready_In),
    .clr_i   (bus.Clear_Overrun_In),
    .cnt_o   (bus.Bit_Count_Out),
    .word_o  (bus.Word_Data_Out),
    .valid_o (bus.Word_Valid_Out),
    .ovr_o   (bus.Overrun_Out)
  );
endmodule

// File: tb/tb_universal_shift_register.sv
// tb_universal_shift_register: vector table, directed corner cases and random run against a word-level model
module tb_universal_shift_register;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  universal_shift_register_if #(.WIDTH(W)) bus();
  universal_shift_register #(.WIDTH(W)) dut (.Clk_In(clk), .Reset_N_In(rstn), .bus(bus));
  always #5 clk = ~clk;
  int         m_reg = 0;
  int         m_cnt = 0;
  int         m_word = 0;
  bit         m_valid = 0;
  bit         m_ovr = 0;
  typedef struct {
    logic en; logic [1:0] mode; logic sin; logic [7:0] pd; logic rdy; logic clr; logic rn;
    logic [7:0] e_reg; int e_cnt; logic e_valid; logic [7:0] e_word; logic e_ovr;
  } vec_t;
  vec_t vq[$];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc(input logic en, input logic [1:0] mode, input logic sin, input logic [W-1:0] pd,
                     input logic rdy, input logic clr, input logic rn);
    bit shift, done, lost;
    int nxt;
    bus.Enable_In = en; bus.Mode_In = mode; bus.Serial_Data_In = sin;
    bus.Parallel_Data_In = pd; bus.Word_Ready_In = rdy; bus.Clear_Overrun_In = clr; rstn = rn;
    if (!rn) begin
      m_reg = 0; m_cnt = 0; m_word = 0; m_valid = 0; m_ovr = 0;
    end else begin
      shift = en && (mode == 2'd1 || mode == 2'd2);
      nxt = !en ? m_reg : mode == 2'd1 ? (m_reg * 2 + int'(sin)) % (2 ** W) :
            mode == 2'd2 ? m_reg / 2 + int'(sin) * (2 ** (W - 1)) : mode == 2'd3 ? int'(pd) : m_reg;
      done = shift && m_cnt == W - 1;
      lost = done && m_valid && !rdy;
      if (en && mode == 2'd3) m_cnt = 0;
      else if (shift) m_cnt = (m_cnt + 1) % W;
      if (m_valid && rdy) m_valid = 0;
      if (clr) m_ovr = 0;
      if (done) begin m_word = nxt; m_valid = 1; end
      if (lost) m_ovr = 1;
      m_reg = nxt;
    end
    @(posedge clk);
    #1;
    chk("reg", 64'(bus.Shift_Register_Out), 64'(m_reg));
    chk("cnt", 64'(bus.Bit_Count_Out), 64'(m_cnt));
    chk("word", 64'(bus.Word_Data_Out), 64'(m_word));
    chk("valid", 64'(bus.Word_Valid_Out), 64'(m_valid));
    chk("ovr", 64'(bus.Overrun_Out), 64'(m_ovr));
    chk("sout", 64'(bus.Serial_Data_Out), 64'(mode == 2'd2 ? m_reg % 2 : m_reg / (2 ** (W - 1))));
  endtask
  task automatic shift_word(input logic [7:0] v, input logic rdy, input logic clr_last);
    for (int i = 7; i >= 0; i--) cyc(1, 2'd1, v[i], 0, rdy, i == 0 ? clr_last : 1'b0, 1);
  endtask
  initial begin
    bus.Enable_In = 0; bus.Mode_In = 0; bus.Serial_Data_In = 0; bus.Parallel_Data_In = 0;
    bus.Word_Ready_In = 0; bus.Clear_Overrun_In = 0;
    vq.push_back('{1'b0, 2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01, 1, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 2, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h05, 3, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h0A, 4, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h14, 5, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h29, 6, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h52, 7, 1'b0, 8'h00, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 0, 1'b1, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 0, 1'b0, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h52, 1, 1'b0, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h29, 2, 1'b0, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h94, 3, 1'b0, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hCA, 4, 1'b0, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hE5, 5, 1'b0, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'hF2, 6, 1'b0, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h79, 7, 1'b0, 8'hA5, 1'b0});
    vq.push_back('{1'b1, 2'd2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 0, 1'b1, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 2'd3, 1'b0, 8'h81, 1'b1, 1'b0, 1'b1, 8'h81, 0, 1'b0, 8'h3C, 1'b0});
    vq.push_back('{1'b0, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h81, 0, 1'b0, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 2'd1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 1, 1'b0, 8'h3C, 1'b0});
    vq.push_back('{1'b1, 2'd3, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b0});
    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].en, vq[i].mode, vq[i].sin, vq[i].pd, vq[i].rdy, vq[i].clr, vq[i].rn);
      chk($sformatf("vec%0d_reg", i), 64'(bus.Shift_Register_Out), 64'(vq[i].e_reg));
      chk($sformatf("vec%0d_cnt", i), 64'(bus.Bit_Count_Out), 64'(vq[i].e_cnt));
      chk($sformatf("vec%0d_valid", i), 64'(bus.Word_Valid_Out), 64'(vq[i].e_valid));
      chk($sformatf("vec%0d_word", i), 64'(bus.Word_Data_Out), 64'(vq[i].e_word));
      chk($sformatf("vec%0d_ovr", i), 64'(bus.Overrun_Out), 64'(vq[i].e_ovr));
      chk($sformatf("vec%0d_sout", i), 64'(bus.Serial_Data_Out),
          64'(vq[i].mode == 2'd2 ? vq[i].e_reg[0] : vq[i].e_reg[7]));
    end
    shift_word(8'h11, 0, 0);
    shift_word(8'h22, 0, 0);
    chk("ovr_word", 64'(bus.Word_Data_Out), 64'h22);
    chk("ovr_valid", 64'(bus.Word_Valid_Out), 64'h1);
    chk("ovr_set", 64'(bus.Overrun_Out), 64'h1);
    cyc(1, 2'd0, 0, 0, 0, 1, 1);
    chk("ovr_clear", 64'(bus.Overrun_Out), 64'h0);
    chk("ovr_clear_valid", 64'(bus.Word_Valid_Out), 64'h1);
    cyc(1, 2'd0, 0, 0, 1, 0, 1);
    chk("accept_valid", 64'(bus.Word_Valid_Out), 64'h0);
    shift_word(8'h11, 0, 0);
    shift_word(8'h22, 0, 1);
    chk("set_wins", 64'(bus.Overrun_Out), 64'h1);
    cyc(1, 2'd3, 0, 8'hA5, 0, 0, 1);
    chk("pre_rst_reg", 64'(bus.Shift_Register_Out), 64'hA5);
    chk("pre_rst_valid", 64'(bus.Word_Valid_Out), 64'h1);
    cyc(1, 2'd1, 1, 8'hA5, 1, 0, 0);
    chk("rst_reg", 64'(bus.Shift_Register_Out), 64'h0);
    chk("rst_word", 64'(bus.Word_Data_Out), 64'h0);
    chk("rst_valid", 64'(bus.Word_Valid_Out), 64'h0);
    chk("rst_ovr", 64'(bus.Overrun_Out), 64'h0);
    chk("rst_sout", 64'(bus.Serial_Data_Out), 64'h0);
    for (int i = 0; i < 3; i++) cyc(1, 2'd2, 1, 0, 0, 0, 1);
    cyc(1, 2'd1, 0, 0, 0, 0, 0);
    cyc(1, 2'd1, 1, 0, 0, 0, 1);
    chk("post_rst_cnt", 64'(bus.Bit_Count_Out), 64'h1);
    cyc(1, 2'd0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2'd1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 2'd1, 0, 0, 0, 0, 1);
    chk("gated_cnt", 64'(bus.Bit_Count_Out), 64'h4);
    for (int i = 0; i < 4; i++) cyc(1, 2'd1, 0, 0, 0, 0, 1);
    chk("gated_valid", 64'(bus.Word_Valid_Out), 64'h1);
    chk("gated_word", 64'(bus.Word_Data_Out), 64'hF0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(7, 0) != 0, 2'($urandom_range(3, 0)), 1'($urandom_range(1, 0)),
          8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), $urandom_range(7, 0) == 0,
          $urandom_range(49, 0) != 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
